// File: rtl/btb_pkg.sv
// Shared types and width helpers for the branch target buffer controller.
package btb_pkg;

   localparam int PC_W_DEF = 16;

   typedef enum logic [1:0] {FLUSH, RUN, DISABLED} btb_state_t;

   typedef struct packed {
      logic [PC_W_DEF-1:0] pc;
      logic [PC_W_DEF-1:0] tgt;
      logic                taken;
   } btb_upd_t;

   function automatic int idx_w(input int entries);
      return $clog2(entries);
   endfunction

   function automatic int tag_w(input int pc_w, input int entries);
      return pc_w - $clog2(entries);
   endfunction

endpackage

// File: rtl/btb_upd_fifo.sv
// Two-deep in-order queue of resolved-branch updates; clr empties it on the next edge.
module btb_upd_fifo
   import btb_pkg::*;
#(
   parameter type T = btb_upd_t
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic push,
   input  logic pop,
   input  T     din,
   output T     head,
   output logic full,
   output logic empty
);

   T           mem [2];
   logic       wp, rp;
   logic [1:0] cnt;
   logic       do_push, do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign full    = (cnt == 2'd2);
   assign empty   = (cnt == 2'd0);
   assign head    = mem[rp];

   always_ff @(posedge clk) begin
      if (do_push) mem[wp] <= din;
   end

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         wp  <= 1'b0;
         rp  <= 1'b0;
         cnt <= 2'd0;
      end else begin
         if (do_push) wp <= ~wp;
         if (do_pop)  rp <= ~rp;
         cnt <= cnt + {1'b0, do_push} - {1'b0, do_pop};
      end
   end

endmodule

// File: rtl/btb_ctrl.sv
// BTB write-port sequencer: bulk invalidate, enable gating and queued EX updates
// written only in cycles fetch leaves the port idle.
module btb_ctrl
   import btb_pkg::*;
#(
   parameter int ENTRIES = 16,
   parameter int PC_W    = 16
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 en_sw,
   input  logic                                 flush_req,
   input  logic                                 lookup_req,
   input  logic                                 upd_vld,
   input  logic [PC_W-1:0]                      upd_pc,
   input  logic [PC_W-1:0]                      upd_tgt,
   input  logic                                 upd_taken,
   output logic                                 upd_rdy,
   output logic                                 btb_we,
   output logic [idx_w(ENTRIES)-1:0]            btb_idx,
   output logic [tag_w(PC_W, ENTRIES)-1:0]      btb_tag,
   output logic [PC_W-1:0]                      btb_tgt,
   output logic                                 btb_valid,
   output logic                                 lookup_en,
   output logic                                 busy
);

   localparam int IDX_W = idx_w(ENTRIES);
   localparam int TAG_W = tag_w(PC_W, ENTRIES);

   typedef struct packed {
      logic [PC_W-1:0] pc;
      logic [PC_W-1:0] tgt;
      logic            taken;
   } upd_t;

   btb_state_t       state, nxt_state;
   logic [IDX_W-1:0] cnt, nxt_cnt;
   logic [1:0]       sync;
   logic             en_s;
   logic             push, pop, clr, full, empty;
   upd_t             din, head;

   assign en_s = sync[1];
   assign din  = '{pc: upd_pc, tgt: upd_tgt, taken: upd_taken};

   btb_upd_fifo #(.T(upd_t)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .clr   (clr),
      .push  (push),
      .pop   (pop),
      .din   (din),
      .head  (head),
      .full  (full),
      .empty (empty)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= FLUSH;
         cnt   <= '0;
         sync  <= 2'b00;
      end else begin
         state <= nxt_state;
         cnt   <= nxt_cnt;
         sync  <= {sync[0], en_sw};
      end
   end

   // All write-port outputs stay quiet while rst is asserted.
   always_comb begin
      nxt_state = state;
      nxt_cnt   = cnt;
      push      = 1'b0;
      pop       = 1'b0;
      clr       = 1'b0;
      upd_rdy   = 1'b0;
      btb_we    = 1'b0;
      btb_idx   = '0;
      btb_tag   = '0;
      btb_tgt   = '0;
      btb_valid = 1'b0;
      if (!rst) begin
         unique case (state)
            FLUSH: begin
               btb_we  = 1'b1;
               btb_idx = cnt;
               upd_rdy = 1'b1;
               if (flush_req) begin
                  nxt_cnt = '0;
               end else if (cnt == IDX_W'(ENTRIES-1)) begin
                  nxt_cnt   = '0;
                  nxt_state = en_s ? RUN : DISABLED;
               end else begin
                  nxt_cnt = cnt + 1'b1;
               end
            end
            RUN: begin
               upd_rdy = !full;
               push    = upd_vld && !full;
               if (!empty && !lookup_req) begin
                  pop       = 1'b1;
                  btb_we    = 1'b1;
                  btb_idx   = head.pc[IDX_W-1:0];
                  btb_tag   = head.pc[PC_W-1:IDX_W];
                  btb_tgt   = head.tgt;
                  btb_valid = head.taken;
               end
               if (flush_req) begin
                  clr       = 1'b1;
                  nxt_state = FLUSH;
                  nxt_cnt   = '0;
               end else if (!en_s) begin
                  clr       = 1'b1;
                  nxt_state = DISABLED;
               end
            end
            DISABLED: begin
               upd_rdy = 1'b1;
               if (en_s) begin
                  nxt_state = FLUSH;
                  nxt_cnt   = '0;
               end
            end
            default: nxt_state = FLUSH;
         endcase
      end
   end

   assign busy      = rst || (state == FLUSH);
   assign lookup_en = !rst && (state == RUN);

endmodule
